exec_datapath: RTL and testbench



---
 rtl/exec_pkg.sv | 83 ++++++++
 rtl/exec_alu_core.sv | 66 ++++++
 rtl/exec_datapath.sv | 142 ++++++++++++++
 tb/tb_exec_datapath.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the decode/execute/memory slice of the 8-bit
// multi-cycle CPU: opcode encoding, control-flag bundle and the decoder.
package exec_pkg;

  localparam int DATA_W  = 8;
  localparam int RADDR_W = 2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SLT  = 4'h8,
    OP_ADDI = 4'h9,
    OP_LW   = 4'hA,
    OP_SW   = 4'hB,
    OP_BEQ  = 4'hC,
    OP_BNE  = 4'hD,
    OP_J    = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Control flags handed to the register file, memory and writeback mux.
  typedef struct packed {
    logic [RADDR_W-1:0] addr_0;
    logic [RADDR_W-1:0] addr_1;
    logic [RADDR_W-1:0] addr_w;
    logic               reg_w_en;
    logic               mem_w_en;
    logic               mem_r_en;
    logic               sel_w_source;
    logic               jump;
  } ctrl_t;

  // Pure decode of one instruction word; anything not listed stays 0.
  function automatic ctrl_t decode_instr(input logic [DATA_W-1:0] instr);
    ctrl_t   c;
    opcode_e op;
    c  = '0;
    op = opcode_e'(instr[7:4]);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
        c.addr_0   = instr[3:2];
        c.addr_1   = instr[1:0];
        c.addr_w   = instr[3:2];
        c.reg_w_en = 1'b1;
      end
      OP_ADDI: begin
        c.addr_0   = instr[3:2];
        c.addr_w   = instr[3:2];
        c.reg_w_en = 1'b1;
      end
      OP_LW: begin
        c.addr_0       = instr[3:2];
        c.addr_w       = instr[1:0];
        c.mem_r_en     = 1'b1;
        c.sel_w_source = 1'b1;
        c.reg_w_en     = 1'b1;
      end
      OP_SW: begin
        c.addr_0   = instr[3:2];
        c.addr_1   = instr[1:0];
        c.mem_w_en = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.addr_0 = instr[3:2];
        c.addr_1 = instr[1:0];
      end
      OP_J: begin
        c.jump = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exec_alu_core.sv
// Combinational 8-bit ALU: result, signed overflow and branch condition
// for one opcode. Arithmetic wraps modulo 256.
module exec_alu_core
  import exec_pkg::*;
(
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        imm,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              cond
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] sum_imm;

  assign sum     = a + b;
  assign diff    = a - b;
  assign sum_imm = a + {{(DATA_W-2){1'b0}}, imm};

  // Opcode-selected result; overflow only for ADD/SUB/ADDI.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    cond     = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum;
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[2:0];
      OP_SRL:  result = a >> b[2:0];
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ADDI: begin
        // The immediate is a small positive number, so overflow can only
        // happen by crossing from positive into negative.
        result   = sum_imm;
        overflow = !a[DATA_W-1] && sum_imm[DATA_W-1];
      end
      OP_BEQ: begin
        result = diff;
        cond   = (a == b);
      end
      OP_BNE: begin
        result = diff;
        cond   = (a != b);
      end
      OP_J:    cond = 1'b1;
      default: begin
        result   = '0;
        overflow = 1'b0;
        cond     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_datapath.sv
// Decode/execute/memory slice of the 8-bit multi-cycle CPU.
// Stage work is gated by the dec_en / exe_en / mem_en strobes from the CPU
// state machine. A strobe is a single-cycle qualifier with no back-pressure:
// the stage acts on every rising edge where its strobe is high, and all
// stages sample pre-edge values, so execute and memory always work on the
// previously latched instruction.
// Optional feature: define OVF_STICKY_EN to add the ovf_sticky output,
// set by any executed overflow and cleared only by rst.
module exec_datapath
  import exec_pkg::*;
#(
  parameter int DMEM_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_en,
  input  logic               exe_en,
  input  logic               mem_en,
  input  logic [DATA_W-1:0]  instr,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  output logic [RADDR_W-1:0] reg_addr_0,
  output logic [RADDR_W-1:0] reg_addr_1,
  output logic [RADDR_W-1:0] reg_addr_w,
  output logic               reg_w_en,
  output logic               mem_w_en,
  output logic               mem_r_en,
  output logic               sel_w_source,
  output logic               jump,
  output logic [DATA_W-1:0]  alu_result,
  output logic               overflow,
  output logic               branch_taken,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  wb_data
`ifdef OVF_STICKY_EN
  ,
  output logic               ovf_sticky
`endif
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              ovf_q, ovf_d;
  logic              br_q, br_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ram_q [DMEM_DEPTH];
  logic [AW-1:0]     mem_addr;
  ctrl_t             ctrl;

  logic [DATA_W-1:0] core_result;
  logic              core_ovf;
  logic              core_cond;

  // Control outputs follow the latched instruction, so they change only
  // the cycle after a dec_en edge and are all zero after reset (NOP).
  assign ctrl         = decode_instr(instr_q);
  assign reg_addr_0   = ctrl.addr_0;
  assign reg_addr_1   = ctrl.addr_1;
  assign reg_addr_w   = ctrl.addr_w;
  assign reg_w_en     = ctrl.reg_w_en;
  assign mem_w_en     = ctrl.mem_w_en;
  assign mem_r_en     = ctrl.mem_r_en;
  assign sel_w_source = ctrl.sel_w_source;
  assign jump         = ctrl.jump;

  exec_alu_core u_alu (
    .op       (opcode_e'(instr_q[7:4])),
    .a        (in0),
    .b        (in1),
    .imm      (instr_q[1:0]),
    .result   (core_result),
    .overflow (core_ovf),
    .cond     (core_cond)
  );

  // Next-state selection for the decode and execute stage registers.
  always_comb begin
    instr_d = dec_en ? instr       : instr_q;
    alu_d   = exe_en ? core_result : alu_q;
    ovf_d   = exe_en ? core_ovf    : ovf_q;
    br_d    = exe_en ? core_cond   : br_q;
  end

  // Decode and execute stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      alu_q   <= '0;
      ovf_q   <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      instr_q <= instr_d;
      alu_q   <= alu_d;
      ovf_q   <= ovf_d;
      br_q    <= br_d;
    end
  end

  // Upper address bits are dropped, so addresses wrap around the RAM.
  assign mem_addr = in0[AW-1:0];

  // Data RAM and load register; reset clears every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        ram_q[i] <= '0;
      end
      rdata_q <= '0;
    end else if (mem_en) begin
      if (ctrl.mem_w_en) begin
        ram_q[mem_addr] <= in1;
      end
      if (ctrl.mem_r_en) begin
        rdata_q <= ram_q[mem_addr];
      end
    end
  end

`ifdef OVF_STICKY_EN
  logic sticky_q;

  // Sticky overflow: remembers any executed overflow until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (exe_en && core_ovf) begin
      sticky_q <= 1'b1;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

  assign alu_result   = alu_q;
  assign overflow     = ovf_q;
  assign branch_taken = br_q;
  assign mem_rdata    = rdata_q;
  assign wb_data      = ctrl.sel_w_source ? rdata_q : alu_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath: hand-computed vectors covering reset,
// decode flags, every ALU class, RAM store/load and branch decisions.
module tb_exec_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_en, exe_en, mem_en;
  logic [7:0] instr, in0, in1;
  logic [1:0] reg_addr_0, reg_addr_1, reg_addr_w;
  logic       reg_w_en, mem_w_en, mem_r_en, sel_w_source, jump;
  logic [7:0] alu_result, mem_rdata, wb_data;
  logic       overflow, branch_taken;
`ifdef OVF_STICKY_EN
  logic       ovf_sticky;
`endif

  int total = 0;
  int bad   = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  exec_datapath #(.DMEM_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_en       (dec_en),
    .exe_en       (exe_en),
    .mem_en       (mem_en),
    .instr        (instr),
    .in0          (in0),
    .in1          (in1),
    .reg_addr_0   (reg_addr_0),
    .reg_addr_1   (reg_addr_1),
    .reg_addr_w   (reg_addr_w),
    .reg_w_en     (reg_w_en),
    .mem_w_en     (mem_w_en),
    .mem_r_en     (mem_r_en),
    .sel_w_source (sel_w_source),
    .jump         (jump),
    .alu_result   (alu_result),
    .overflow     (overflow),
    .branch_taken (branch_taken),
    .mem_rdata    (mem_rdata),
    .wb_data      (wb_data)
`ifdef OVF_STICKY_EN
    ,
    .ovf_sticky   (ovf_sticky)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the edge, outputs are
  // sampled there too, well away from the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_dec(input logic [7:0] i);
    instr  = i;
    dec_en = 1'b1;
    tick();
    dec_en = 1'b0;
  endtask

  task automatic do_exe(input logic [7:0] a, input logic [7:0] b);
    in0    = a;
    in1    = b;
    exe_en = 1'b1;
    tick();
    exe_en = 1'b0;
  endtask

  task automatic do_mem(input logic [7:0] a, input logic [7:0] b);
    in0    = a;
    in1    = b;
    mem_en = 1'b1;
    tick();
    mem_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dec_en = 1'b0; exe_en = 1'b0; mem_en = 1'b0;
    instr = 8'h00; in0 = 8'h00; in1 = 8'h00;
    tick();
    rst = 1'b0;

    // Put data into RAM and a nonzero result in the stage registers first,
    // so the later reset has something to clear.
    do_dec(8'hB0);                       // SW
    do_mem(8'h05, 8'h5A);                // RAM[5] = 5A
    do_dec(8'h16);
    do_exe(8'h7F, 8'h01);

    // Reset with every strobe high: reset must win.
    rst = 1'b1; dec_en = 1'b1; exe_en = 1'b1; mem_en = 1'b1;
    instr = 8'h16; in0 = 8'h7F; in1 = 8'h01;
    tick();
    tick();
    rst = 1'b0; dec_en = 1'b0; exe_en = 1'b0; mem_en = 1'b0;
    chk("rst_alu_result", alu_result, 8'h00);
    chk("rst_overflow", {7'b0, overflow}, 8'h00);
    chk("rst_branch", {7'b0, branch_taken}, 8'h00);
    chk("rst_mem_rdata", mem_rdata, 8'h00);
    chk("rst_wb_data", wb_data, 8'h00);
    chk("rst_flags", {reg_w_en, mem_w_en, mem_r_en, sel_w_source, jump, 3'b0}, 8'h00);
    chk("rst_addrs", {2'b0, reg_addr_0, reg_addr_1, reg_addr_w}, 8'h00);

    // LW 8'hA6: addr_0 = 1, addr_w = 2; reading the old address returns 0.
    do_dec(8'hA6);
    chk("lw_flags", {reg_w_en, mem_w_en, mem_r_en, sel_w_source, jump, 3'b0}, 8'b1011_0000);
    chk("lw_addr_0", {6'b0, reg_addr_0}, 8'h01);
    chk("lw_addr_w", {6'b0, reg_addr_w}, 8'h02);
    do_mem(8'h05, 8'hEE);
    chk("lw_after_rst", mem_rdata, 8'h00);

    // ADD r1,r2: 7F + 01 = 80 with signed overflow.
    do_dec(8'h16);
    chk("add_reg_w_en", {7'b0, reg_w_en}, 8'h01);
    chk("add_addr_w", {6'b0, reg_addr_w}, 8'h01);
    chk("add_addr_1", {6'b0, reg_addr_1}, 8'h02);
    do_exe(8'h7F, 8'h01);
    chk("add_result", alu_result, 8'h80);
    chk("add_ovf", {7'b0, overflow}, 8'h01);
    chk("add_wb", wb_data, 8'h80);

    // instr changes without dec_en are ignored; ADD stays latched.
    instr = 8'h20;
    tick();
    do_exe(8'h01, 8'h02);
    chk("no_dec_ignored", alu_result, 8'h03);

    // Same-edge decode and execute: execute uses the old (ADD) instruction.
    instr = 8'h50; dec_en = 1'b1; in0 = 8'h10; in1 = 8'h20; exe_en = 1'b1;
    tick();
    dec_en = 1'b0; exe_en = 1'b0;
    chk("same_edge_old", alu_result, 8'h30);
    do_exe(8'hF0, 8'h3C);
    chk("xor_result", alu_result, 8'hCC);
    chk("xor_ovf", {7'b0, overflow}, 8'h00);

    // Held when exe_en is low.
    in0 = 8'h00; in1 = 8'h00;
    tick();
    chk("alu_held", alu_result, 8'hCC);

    do_dec(8'h30); do_exe(8'hF0, 8'h3C);
    chk("and_result", alu_result, 8'h30);
    do_dec(8'h40); do_exe(8'hF0, 8'h3C);
    chk("or_result", alu_result, 8'hFC);

    // SUB: 00 - 01 wraps to FF, no overflow; 80 - 01 = 7F overflows.
    do_dec(8'h21);
    do_exe(8'h00, 8'h01);
    chk("sub_wrap", alu_result, 8'hFF);
    chk("sub_wrap_ovf", {7'b0, overflow}, 8'h00);
    do_exe(8'h80, 8'h01);
    chk("sub_ovf_result", alu_result, 8'h7F);
    chk("sub_ovf", {7'b0, overflow}, 8'h01);

    // Shifts use in1[2:0] only: 0B -> shift by 3.
    do_dec(8'h60); do_exe(8'h81, 8'h0B);
    chk("sll_result", alu_result, 8'h08);
    do_dec(8'h70); do_exe(8'h81, 8'h0B);
    chk("srl_result", alu_result, 8'h10);

    // SLT is signed: -1 < 1, but 1 < -1 is false.
    do_dec(8'h80); do_exe(8'hFF, 8'h01);
    chk("slt_true", alu_result, 8'h01);
    do_exe(8'h01, 8'hFF);
    chk("slt_false", alu_result, 8'h00);

    // ADDI r1, 3: 7E + 3 = 81, crosses into negative.
    do_dec(8'h97);
    chk("addi_addr_1", {6'b0, reg_addr_1}, 8'h00);
    chk("addi_addr_w", {6'b0, reg_addr_w}, 8'h01);
    do_exe(8'h7E, 8'hFF);
    chk("addi_result", alu_result, 8'h81);
    chk("addi_ovf", {7'b0, overflow}, 8'h01);

    // SW to 8'h13 (wraps to word 3), then LW from 3.
    do_dec(8'hB1);
    chk("sw_flags", {reg_w_en, mem_w_en, mem_r_en, sel_w_source, jump, 3'b0}, 8'b0100_0000);
    do_mem(8'h13, 8'hA5);
    chk("rdata_held_on_store", mem_rdata, 8'h00);
    do_dec(8'hA0);
    do_mem(8'h03, 8'h00);
    chk("lw_rdata", mem_rdata, 8'hA5);
    chk("lw_wb", wb_data, 8'hA5);

    // Branches and jump.
    do_dec(8'hC1); do_exe(8'h42, 8'h42);
    chk("beq_taken", {7'b0, branch_taken}, 8'h01);
    chk("beq_result", alu_result, 8'h00);
    do_dec(8'hD1); do_exe(8'h42, 8'h42);
    chk("bne_not_taken", {7'b0, branch_taken}, 8'h00);
    do_exe(8'h42, 8'h43);
    chk("bne_taken", {7'b0, branch_taken}, 8'h01);
    chk("bne_result", alu_result, 8'hFF);
    do_dec(8'hE0);
    chk("j_jump", {7'b0, jump}, 8'h01);
    do_exe(8'h00, 8'h00);
    chk("j_branch", {7'b0, branch_taken}, 8'h01);

    // HALT: all flags 0 and result 0.
    do_dec(8'hF5);
    do_exe(8'h05, 8'h07);
    chk("halt_result", alu_result, 8'h00);
    chk("halt_flags", {reg_w_en, mem_w_en, mem_r_en, sel_w_source, jump, branch_taken, overflow, 1'b0}, 8'h00);

`ifdef OVF_STICKY_EN
    chk("ovf_sticky_set", {7'b0, ovf_sticky}, 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
